uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 2..256).
REQ-002 SHALL have parameter DATA_W, default 8, byte width (fixed at 8; other values unsupported).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_en  input  1  write strobe from producer.
REQ-006 SHALL have port wr_data  input  8  byte to queue.
REQ-007 SHALL have port full  output  1  no free entry.
REQ-008 SHALL have port empty  output  1  no queued entry.
REQ-009 SHALL have port count  output  clog2(DEPTH)+1  entries queued.
REQ-010 SHALL have port overflow  output  1  sticky dropped-write flag.
REQ-011 SHALL have port txStart  output  1  launch pulse to UART transmitter.
REQ-012 SHALL have port txData  output  8  byte presented to UART transmitter input.
REQ-013 SHALL have port txBusy  input  1  UART transmitter busy.
REQ-014 SHALL have port txDone  input  1  UART transmitter frame-complete pulse.

Function
REQ-015 SHALL accept a write at a clock edge iff wr_en=1 and full=0 (registered value), storing wr_data at write pointer and incrementing it modulo DEPTH.
REQ-016 SHALL drop wr_en when full=1, leaving storage, pointers and count unchanged.
REQ-017 SHALL keep count unchanged on a same-edge accepted write and pop; +1 on write only; -1 on pop only.
REQ-018 SHALL derive full=(count==DEPTH) and empty=(count==0), both registered-consistent with count.
REQ-019 SHALL wrap read/write pointers from DEPTH-1 to 0 without gaps.
REQ-020 SHALL run sequencer states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-021 IDLE: if empty=0 and txBusy=0, pop head into txData, set txStart=1, go LAUNCH; else stay.
REQ-022 LAUNCH: set txStart=0 (pulse exactly one cycle); go WAIT_BUSY.
REQ-023 WAIT_BUSY: on txBusy=1 go WAIT_DONE; on txDone=1 go IDLE.
REQ-024 WAIT_DONE: on txDone=1 go IDLE; txBusy falling without txDone also returns to IDLE.
REQ-025 SHALL hold txData stable from the txStart cycle until the next pop.
REQ-026 Latency: write accepted at edge N into empty FIFO with idle UART -> txStart high in cycle following edge N+1.
REQ-027 Back-to-back: next pop SHALL occur no earlier than the edge after txDone is seen; at most one byte in flight.
REQ-028 Writes SHALL be accepted in every sequencer state.

Reset
REQ-029 On rst=1 at an edge: pointers=0, count=0, empty=1, full=0, overflow=0, txStart=0, txData=8'h00, state=IDLE; stored data need not clear.
REQ-030 rst mid-frame SHALL discard queued bytes; after release, no launch until txBusy=0.
REQ-031 rst SHALL dominate simultaneous wr_en and sequencer pop.

Configuration
REQ-032 Macro UART_TX_FIFO_OVERFLOW_EN defined: overflow SHALL set on the edge of a dropped write (REQ-016) and hold until rst.
REQ-033 Macro undefined: overflow SHALL be constant 0, no flag logic; all other behaviour identical.

Verification
REQ-034 Reset then write 0xA5 with txBusy=0 -> txStart one-cycle pulse two edges later, txData=0xA5, count back to 0.
REQ-035 Write 0x01..0x10 (16) with txBusy=1 held -> full=1, count=16, no txStart; 17th write 0xFF dropped, overflow=1 (macro on) / 0 (macro off).
REQ-036 Queue 0x11,0x22,0x33; UART model busy 10 cycles then txDone -> three txStart pulses in order 0x11,0x22,0x33, each after preceding txDone.
REQ-037 Count=DEPTH-1, write and pop same edge -> count stays DEPTH-1, full stays 0; pointer wrap verified over 40 bytes with no loss or reorder.
REQ-038 rst asserted in WAIT_DONE with 5 queued -> count=0, txStart=0, no further launch until txBusy=0 and new write.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds a UART transmitter through a one-byte-in-flight launch sequencer.
// Define UART_TX_FIFO_OVERFLOW_EN to build the sticky overflow flag; otherwise overflow is tied low.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   txStart,
    output logic [DATA_W-1:0]      txData,
    input  logic                   txBusy,
    input  logic                   txDone
);
    // state     | meaning
    // IDLE      | waiting for a queued byte and an idle transmitter
    // LAUNCH    | txStart high for exactly this cycle
    // WAIT_BUSY | waiting for the transmitter to raise txBusy
    // WAIT_DONE | frame in progress, waiting for txDone or txBusy to drop

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              wr_accept;
    logic              pop;

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign wr_accept = wr_en && !full;

    // Storage is not reset; pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            txData <= '0;
        end else begin
            if (wr_accept)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                txData <= mem[rd_ptr];
            end
            case ({wr_accept, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A drop of txBusy in WAIT_DONE without txDone is treated as an aborted frame.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!empty && !txBusy) state_nxt = LAUNCH;
            LAUNCH:    state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (txDone)
                    state_nxt = IDLE;
                else if (txBusy)
                    state_nxt = WAIT_DONE;
            end
            WAIT_DONE: if (txDone || !txBusy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        txStart = 1'b0;
        pop     = 1'b0;
        case (state)
            IDLE:    pop     = !empty && !txBusy;
            LAUNCH:  txStart = 1'b1;
            default: ;
        endcase
    end

`ifdef UART_TX_FIFO_OVERFLOW_EN
    always_ff @(posedge clk) begin
        if (rst)
            overflow <= 1'b0;
        else if (wr_en && full)
            overflow <= 1'b1;
    end
`else
    assign overflow = 1'b0;
`endif

endmodule
